// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and
// helpers classifying the iterative operations.
package seq_alu_pkg;

    // Original combinational ALU codes come first so existing decoders stay valid.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SRL    = 5'd3,
        ALU_SRA    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_OR     = 5'd7,
        ALU_AND    = 5'd8,
        ALU_ADDI   = 5'd9,
        ALU_EQL    = 5'd10,
        ALU_SLTU   = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19
    } ALU_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } seq_alu_state_t;

    function automatic logic is_mul(input ALU_op_t op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div(input ALU_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring divider working on magnitudes; one quotient bit per
// clock, final quotient/remainder signs applied combinationally on the last step.
module seq_alu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic            running;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsr;
    logic            neg_q;
    logic            neg_r;

    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] rem_n;

    // A partial remainder below the divisor always fits in XLEN bits, so the
    // truncation on the restore path loses nothing.
    always_comb begin
        trial = {rem, quo[XLEN-1]};
        fits  = (trial >= {1'b0, dsr});
        rem_n = fits ? XLEN'(trial - {1'b0, dsr}) : XLEN'(trial);
        quo_n = {quo[XLEN-2:0], fits};
    end

    assign done      = running && (cnt == CNT_LAST);
    assign quotient  = neg_q ? -quo_n : quo_n;
    assign remainder = neg_r ? -rem_n : rem_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dsr     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            quo     <= (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
            rem     <= '0;
            dsr     <= (signed_op && divisor[XLEN-1]) ? -divisor : divisor;
            neg_q   <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r   <= signed_op && dividend[XLEN-1];
        end else if (running) begin
            quo <= quo_n;
            rem <= rem_n;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: RV32I ops in one cycle, RV32M multiply and
// divide iteratively, behind valid/ready with a registered, held result.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  ALU_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    // IDLE accepts | MUL/DIV iterate XLEN steps | DONE holds result until taken
    seq_alu_state_t state, state_n;

    ALU_op_t           op_q;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic              mul_neg;
    logic [CW-1:0]     mul_cnt;

    logic              accept;
    logic              div_signed;
    logic              div_is_rem;
    logic              div_fast;
    logic              div_start;
    logic              div_done;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   fast_result;
    logic [XLEN-1:0]   alu_result;
    logic              a_sgn;
    logic              b_sgn;
    logic [XLEN:0]     mul_add;
    logic [2*XLEN-1:0] prod_n;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_result;
    logic [SHW-1:0]    shamt;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];

    always_comb begin
        div_signed  = (op == ALU_DIV) || (op == ALU_REM);
        div_is_rem  = (op == ALU_REM) || (op == ALU_REMU);
        fast_result = '0;
        div_fast    = 1'b0;
        if (b == '0) begin
            div_fast    = 1'b1;
            fast_result = div_is_rem ? a : '1;
        end else if (div_signed && (a == MIN_NEG) && (b == '1)) begin
            div_fast    = 1'b1;
            fast_result = div_is_rem ? '0 : a;
        end
        div_start = accept && is_div(op) && !div_fast;
    end

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:  alu_result = a + b;
            ALU_SUB:  alu_result = a - b;
            ALU_SLL:  alu_result = a << shamt;
            ALU_SRL:  alu_result = a >> shamt;
            ALU_SRA:  alu_result = $signed(a) >>> shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  alu_result = a ^ b;
            ALU_OR:   alu_result = a | b;
            ALU_AND:  alu_result = a & b;
            ALU_ADDI: alu_result = a + imm;
            ALU_EQL:  alu_result = {{(XLEN-1){1'b0}}, (a == b)};
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_result = fast_result;
            default:  alu_result = '0;
        endcase
    end

    // Multiplier runs unsigned on magnitudes; product holds the multiplier in
    // its low half and shifts right one bit per step.
    always_comb begin
        a_sgn      = ((op == ALU_MULH) || (op == ALU_MULHSU)) && a[XLEN-1];
        b_sgn      = (op == ALU_MULH) && b[XLEN-1];
        mul_add    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_n     = {mul_add, prod[XLEN-1:1]};
        prod_fix   = mul_neg ? -prod_n : prod_n;
        mul_result = (op_q == ALU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    seq_alu_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (div_signed),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul(op))     state_n = ST_MUL;
                    else if (div_start) state_n = ST_DIV;
                    else                state_n = ST_DONE;
                end
            end
            ST_MUL:  if (mul_cnt == CNT_LAST) state_n = ST_DONE;
            ST_DIV:  if (div_done) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            op_q    <= ALU_ADD;
            mcand   <= '0;
            prod    <= '0;
            mul_neg <= 1'b0;
            mul_cnt <= '0;
        end else begin
            if (accept) begin
                op_q    <= op;
                mcand   <= a_sgn ? -a : a;
                prod    <= {{XLEN{1'b0}}, (b_sgn ? -b : b)};
                mul_neg <= a_sgn ^ b_sgn;
                mul_cnt <= '0;
                if (!is_mul(op) && !div_start) result <= alu_result;
            end
            if (state == ST_MUL) begin
                prod    <= prod_n;
                mul_cnt <= mul_cnt + CW'(1);
                if (mul_cnt == CNT_LAST) result <= mul_result;
            end
            if ((state == ST_DIV) && div_done) begin
                result <= ((op_q == ALU_REM) || (op_q == ALU_REMU)) ? div_rem : div_quo;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized ops
// compared against a wide-arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    ALU_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
        logic signed [63:0] xs, ys, sp;
        logic [63:0] xu, yu, up;
        int xi, yi;
        xs = $signed(x);
        ys = $signed(y);
        xu = {32'd0, x};
        yu = {32'd0, y};
        xi = x;
        yi = y;
        case (o)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x << y[4:0];
            5'd3:  return x >> y[4:0];
            5'd4:  return $signed(x) >>> y[4:0];
            5'd5:  return (xi < yi) ? 32'd1 : 32'd0;
            5'd6:  return x ^ y;
            5'd7:  return x | y;
            5'd8:  return x & y;
            5'd9:  return x + z;
            5'd10: return (x == y) ? 32'd1 : 32'd0;
            5'd11: return (x < y) ? 32'd1 : 32'd0;
            5'd12: begin up = xu * yu; return up[31:0]; end
            5'd13: begin sp = xs * ys; return sp[63:32]; end
            5'd14: begin sp = xs * $signed(yu); return sp[63:32]; end
            5'd15: begin up = xu * yu; return up[63:32]; end
            5'd16: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MINV && y == 32'hFFFF_FFFF) return x;
                return xi / yi;
            end
            5'd17: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd18: begin
                if (y == 0) return x;
                if (x == MINV && y == 32'hFFFF_FFFF) return 32'd0;
                return xi % yi;
            end
            5'd19: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 5'd12 && o <= 5'd15) return 33;
        if (o >= 5'd16 && o <= 5'd19) begin
            if (y == 0) return 1;
            if ((o == 5'd16 || o == 5'd18) && x == MINV && y == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input string tag, input bit stall);
        int n;
        int lat;
        int hold;
        logic [31:0] exp;
        exp = model(o, x, y, z);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = ALU_op_t'(o);
        a = x;
        b = y;
        imm = z;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        imm = $urandom;
        op = ALU_op_t'(5'($urandom));
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk({tag, ":busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(exp_latency(o, x, y)));
        chk({tag, ":result"}, result, exp);
        if (stall) begin
            hold = $urandom_range(1, 3);
            @(negedge clk);
            out_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                #1;
                chk({tag, ":held"}, result, exp);
                chk({tag, ":held_valid"}, 32'(out_valid), 32'd1);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = ALU_ADD;
        a = '0;
        b = '0;
        imm = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:result", result, 32'd0);
        chk("reset:in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_op(5'd0,  32'h7FFF_FFFF, 32'd1,         32'd0, "add_ovf", 1'b0);
        run_op(5'd4,  MINV,          32'd4,         32'd0, "sra", 1'b0);
        run_op(5'd13, 32'hFFFF_FFFF, 32'd2,         32'd0, "mulh", 1'b0);
        run_op(5'd12, 32'hFFFF_FFFF, 32'd2,         32'd0, "mul", 1'b0);
        run_op(5'd16, 32'hFFFF_FFF9, 32'd2,         32'd0, "div_neg", 1'b0);
        run_op(5'd18, 32'hFFFF_FFF9, 32'd2,         32'd0, "rem_neg", 1'b0);
        run_op(5'd19, 32'd7,         32'd0,         32'd0, "remu_zero", 1'b0);
        run_op(5'd16, MINV,          32'hFFFF_FFFF, 32'd0, "div_ovf", 1'b0);
        run_op(5'd17, 32'd5,         32'd0,         32'd0, "divu_zero", 1'b0);
        run_op(5'd9,  32'd10,        32'd0, 32'hFFFF_FFFD, "addi", 1'b0);
        run_op(5'd25, 32'd3,         32'd4,         32'd0, "unknown", 1'b0);

        // Backpressure: result held, second request waits for IDLE
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            out_ready = 1'b0;
            in_valid = 1'b1;
            op = ALU_ADD;
            a = 32'd10;
            b = 32'd20;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp:first_valid", 32'(out_valid), 32'd1);
            chk("bp:first_result", result, 32'd30);
            repeat (5) begin
                @(negedge clk);
                in_valid = 1'b1;
                op = ALU_SUB;
                a = 32'd100;
                b = 32'd1;
                @(posedge clk);
                #1;
                chk("bp:stable", result, 32'd30);
                chk("bp:in_ready_low", 32'(in_ready), 32'd0);
                chk("bp:valid_held", 32'(out_valid), 32'd1);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp:idle_valid", 32'(out_valid), 32'd0);
            chk("bp:idle_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp:second_valid", 32'(out_valid), 32'd1);
            chk("bp:second_result", result, 32'd99);
        end

        // Reset in the middle of a multiply
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            in_valid = 1'b1;
            op = ALU_MUL;
            a = 32'd1234;
            b = 32'd5678;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk("rstmid:busy_before", 32'(busy), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("rstmid:out_valid", 32'(out_valid), 32'd0);
            chk("rstmid:busy", 32'(busy), 32'd0);
            chk("rstmid:result", result, 32'd0);
            chk("rstmid:in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            rst = 1'b0;
            run_op(5'd0, 32'd2, 32'd3, 32'd0, "post_rst_add", 1'b0);
            repeat (40) @(posedge clk);
            #1;
            chk("rstmid:no_late_valid", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [4:0] o;
            o = 5'($urandom_range(0, 23));
            run_op(o, pick_operand(), pick_operand(), pick_operand(), "rand",
                   ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the core's combinational ALU.
- Executes the RV32I integer ops in one cycle and the RV32M multiply/divide ops with an iterative datapath.
- Sits in the execute stage behind a valid/ready handshake, so the core stalls only on long ops.
- Result is registered and held until consumed.

Parameters:
- XLEN, 32, operand/result width; must be even, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  ALU_op_t (5)  operation select
- a  in  XLEN  operand r1
- b  in  XLEN  operand r2
- imm  in  XLEN  signed immediate, used by ADDI only
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- busy  out  1  iterative op in progress

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 after reset. Reset mid-operation aborts the op with no result.
- Handshake: request accepted when in_valid && in_ready. in_ready = (state==IDLE). Operands and op are latched on accept; inputs are don't-care afterwards.
- Output: out_valid stays high with result stable until out_ready=1. The transfer (out_valid && out_ready) returns the block to IDLE on that edge. No new request is accepted in the transfer cycle.
- States:
  - IDLE: on accept, single-cycle op -> DONE; MUL* -> MUL; DIV/REM* -> DIV (or DONE via the fast paths below).
  - MUL: runs XLEN iterations, then -> DONE.
  - DIV: runs XLEN iterations, then -> DONE.
  - DONE: out_valid=1; -> IDLE on transfer.
- busy=1 in MUL and DIV.
- Latency, accept edge to out_valid:
  - single-cycle ops: 1 cycle
  - MUL*/DIV*: XLEN+1 cycles
  - divide fast paths: 1 cycle
- Single-cycle ops:
  - ADD, SUB: a+b, a-b, modulo 2^XLEN.
  - SLL/SRL/SRA: shift by b[SHW-1:0]. SRA is a true arithmetic shift of signed a.
  - SLT: signed compare. SLTU: unsigned compare. Both produce 0/1 in the LSB.
  - XOR, OR, AND: bitwise.
  - ADDI: a+imm.
  - EQL: (a==b) as 0/1.
  - Unknown op codes: result 0, latency 1.
- MUL:
  - Shift-add over an XLEN-bit counter with a 2*XLEN product register.
  - Operands are sign-corrected per op: MULH signed×signed, MULHSU signed a × unsigned b, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- DIV:
  - Restoring divider on magnitudes; signs are fixed after the last iteration.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Fast paths, both 1-cycle:
    - b==0: DIV/DIVU quotient = all ones, REM/REMU = a.
    - Signed overflow (a = most negative, b = -1): DIV = a, REM = 0.
- Counter: SHW+1 bits. It is loaded on accept and compared to XLEN-1 for the exit, so there is no wrap.

Decomposition:
- TypesPkg gains:
  - ALU_op_t, 5-bit enum: existing codes kept first, then SLTU, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - seq_alu_state_t: IDLE, MUL, DIV, DONE.
  - Helper functions is_mul(op) and is_div(op).
- Sub-module seq_alu_divider holds the iterative restoring divider: start, done, signed flag, quotient, remainder.
- The shift-add multiplier stays inline in seq_alu.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, out_valid 1 cycle after accept. SRA a=0x80000000, b=4 -> 0xF8000000.
- MULH a=0xFFFFFFFF (-1), b=2 -> 0xFFFFFFFF, MUL same operands -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept; busy high throughout.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REMU a=7, b=0 -> 7 after 1 cycle.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, 1-cycle latency. DIVU a=5, b=0 -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles -> result stable, in_ready=0, a second in_valid ignored. Release -> IDLE next cycle, then the second request is accepted.
- Assert rst during MUL iteration 10 -> next cycle out_valid=0, busy=0, result=0, in_ready=1. A following ADD 2+3 -> 5.
